tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Time-division 1-to-4 demultiplexer, the receive end of the 4-way selector path.
- Accepts a serial stream of samples, one per valid cycle, framed by a sync marker on slot 0.
- Routes each sample to one of four registered output lanes, using an internal slot counter in place of an external select.
- Flags frame completion and sync misalignment for downstream logic.

Parameters:
- WIDTH, 1, bit width of each sample and of each output lane.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- din  input  WIDTH  incoming sample.
- din_valid  input  1  din is a valid sample this cycle.
- sync  input  1  marks the current valid sample as slot 0 of a frame; ignored when din_valid=0.
- y0  output  WIDTH  lane 0 registered data.
- y1  output  WIDTH  lane 1 registered data.
- y2  output  WIDTH  lane 2 registered data.
- y3  output  WIDTH  lane 3 registered data.
- lane_stb  output  4  one-hot pulse; bit k high for one cycle when yk is updated.
- slot  output  2  index of the lane the next valid sample will be written to.
- locked  output  1  high once the first sync has been accepted.
- frame_done  output  1  one-cycle pulse when a lane-3 write completes a frame.
- sync_err  output  1  one-cycle pulse when sync arrives while slot != 0 in LOCK.

Behaviour:
- Reset is synchronous: at a rising edge of clk with rst_n=0, y0..y3=0, lane_stb=0, slot=0, locked=0, frame_done=0, sync_err=0, state=HUNT.
- rst_n has priority over every other input.
- All outputs are registered. Latency is 1 cycle: a sample accepted at edge N is visible on yk, with its lane_stb bit set, immediately after edge N.
- States: HUNT and LOCK.
- HUNT, din_valid=0: no change.
- HUNT, din_valid=1 and sync=0: sample discarded, no strobe, slot stays 0.
- HUNT, din_valid=1 and sync=1: write din to y0, lane_stb=0001, slot->1, locked->1, state->LOCK.
- LOCK, din_valid=0: yk hold, lane_stb=0, frame_done=0, sync_err=0, slot holds. Gaps of any length are allowed mid-frame.
- LOCK, din_valid=1 and sync=0: write din to y[slot], set lane_stb bit [slot], slot->slot+1 mod 4 (3 wraps to 0).
- LOCK, din_valid=1, sync=0 and slot=3: additionally frame_done=1 for that cycle.
- LOCK, din_valid=1, sync=1 and slot=0: normal slot-0 write, no error.
- LOCK, din_valid=1, sync=1 and slot!=0 (resync): sync_err=1 for one cycle, din written to y0, lane_stb=0001, slot->1. frame_done is not asserted for the truncated frame. Lanes not yet written in the aborted frame keep their previous values.
- lane_stb, frame_done and sync_err are 0 in every cycle where no write occurs. They never stay high for two cycles unless a qualifying event occurs on each of those cycles.
- Outputs yk are only ever overwritten as a whole WIDTH-bit word. No partial updates.
- Reset asserted mid-frame: the next cycle is in HUNT with all lanes zero. A frame interrupted by reset is never completed.
- Reset deassertion: the first edge with rst_n=1 is a normal HUNT cycle, so a sync-qualified sample on that edge is accepted.

Test Plan (WIDTH=4):
- Reset then basic frame: rst_n=0 for 2 cycles, then valid samples 0x1 (sync=1), 0x2, 0x3, 0x4 on consecutive cycles -> y0..y3 = 1,2,3,4. lane_stb sequence 0001,0010,0100,1000. frame_done high only in the cycle after 0x4. slot sequence 1,2,3,0.
- Hunt discard: valid 0xA, 0xB with sync=0 after reset, then 0xC with sync=1 -> no strobes and y0..y3=0 until the 0xC edge. Then y0=0xC, locked=1, slot=1.
- Gaps: locked frame 0x5 (sync), idle, idle, 0x6, idle, 0x7, 0x8 -> y1=0x6, y2=0x7, y3=0x8. Outputs stable during idle cycles, lane_stb=0 in idle cycles. frame_done is a single pulse after 0x8.
- Misaligned sync: after 0x1 (sync) and 0x2, send 0x9 with sync=1 -> sync_err pulses once, y0=0x9, y1 stays 0x2, slot=1, no frame_done.
- Back-to-back frames with wrap: 8 consecutive valid samples 0x0..0x7, sync on 0x0 and 0x4 -> y0..y3 = 4,5,6,7 at the end. frame_done pulses after 0x3 and after 0x7. sync_err never asserted.
- Reset mid-frame: after 0x1 (sync) and 0x2, drive rst_n=0 for one edge -> all y=0, locked=0, slot=0. A subsequent 0x3 with sync=0 is discarded.

Source files
------------

// File: rtl/tdm_demux4.sv
// Time-division 1-to-4 demultiplexer: routes a framed serial sample stream onto
// four registered lanes, tracking the slot position internally after the first sync.
module tdm_demux4 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic [3:0]       lane_stb,
   output logic [1:0]       slot,
   output logic             locked,
   output logic             frame_done,
   output logic             sync_err
);

   typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] y_q [4];
   logic [WIDTH-1:0] y_d [4];
   logic [3:0]       stb_q, stb_d;
   logic [1:0]       slot_q, slot_d;
   logic             locked_q, locked_d;
   logic             fd_q, fd_d;
   logic             se_q, se_d;

   // Next-state: pulses default low, lanes and slot hold unless a write occurs.
   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      stb_d    = 4'b0000;
      slot_d   = slot_q;
      locked_d = locked_q;
      fd_d     = 1'b0;
      se_d     = 1'b0;
      case (state_q)
         HUNT: begin
            if (din_valid && sync) begin
               y_d[0]   = din;
               stb_d    = 4'b0001;
               slot_d   = 2'd1;
               locked_d = 1'b1;
               state_d  = LOCK;
            end else begin
               state_d = HUNT;
            end
         end
         LOCK: begin
            if (din_valid && sync) begin
               // A sync always restarts the frame at slot 0; off-slot ones are flagged.
               se_d   = (slot_q != 2'd0);
               y_d[0] = din;
               stb_d  = 4'b0001;
               slot_d = 2'd1;
            end else if (din_valid) begin
               y_d[slot_q] = din;
               stb_d       = 4'b0001 << slot_q;
               slot_d      = slot_q + 2'd1;
               fd_d        = (slot_q == 2'd3);
            end else begin
               slot_d = slot_q;
            end
         end
         default: begin
            state_d = HUNT;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= HUNT;
         for (int i = 0; i < 4; i++) begin
            y_q[i] <= '0;
         end
         stb_q    <= 4'b0000;
         slot_q   <= 2'd0;
         locked_q <= 1'b0;
         fd_q     <= 1'b0;
         se_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         y_q      <= y_d;
         stb_q    <= stb_d;
         slot_q   <= slot_d;
         locked_q <= locked_d;
         fd_q     <= fd_d;
         se_q     <= se_d;
      end
   end

   assign y0         = y_q[0];
   assign y1         = y_q[1];
   assign y2         = y_q[2];
   assign y3         = y_q[3];
   assign lane_stb   = stb_q;
   assign slot       = slot_q;
   assign locked     = locked_q;
   assign frame_done = fd_q;
   assign sync_err   = se_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 with WIDTH=4; every expected
// value below is hand-computed from the frame/slot rules.
module tb_tdm_demux4;

   logic       clk;
   logic       rst_n;
   logic [3:0] din;
   logic       din_valid;
   logic       sync;
   logic [3:0] y0, y1, y2, y3;
   logic [3:0] lane_stb;
   logic [1:0] slot;
   logic       locked;
   logic       frame_done;
   logic       sync_err;

   int n_checks;
   int n_fail;

   tdm_demux4 #(.WIDTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .sync       (sync),
      .y0         (y0),
      .y1         (y1),
      .y2         (y2),
      .y3         (y3),
      .lane_stb   (lane_stb),
      .slot       (slot),
      .locked     (locked),
      .frame_done (frame_done),
      .sync_err   (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Applies one cycle of stimulus, then samples 1 time unit after the edge.
   task automatic step(input logic rn, input logic v, input logic s, input logic [3:0] d);
      rst_n     = rn;
      din_valid = v;
      sync      = s;
      din       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_all(input string tag,
                             input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3,
                             input logic [3:0] estb, input logic [1:0] eslot,
                             input logic elk, input logic efd, input logic ese);
      check({tag, ".y0"}, y0, e0);
      check({tag, ".y1"}, y1, e1);
      check({tag, ".y2"}, y2, e2);
      check({tag, ".y3"}, y3, e3);
      check({tag, ".stb"}, lane_stb, estb);
      check({tag, ".slot"}, {2'b00, slot}, {2'b00, eslot});
      check({tag, ".locked"}, {3'b000, locked}, {3'b000, elk});
      check({tag, ".fdone"}, {3'b000, frame_done}, {3'b000, efd});
      check({tag, ".serr"}, {3'b000, sync_err}, {3'b000, ese});
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      din_valid = 1'b0;
      sync      = 1'b0;
      din       = 4'h0;

      // Reset for 2 cycles with a sync-qualified sample present: reset wins.
      step(1'b0, 1'b1, 1'b1, 4'hF);
      step(1'b0, 1'b1, 1'b1, 4'hF);
      expect_all("rst", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

      // Basic frame; first edge after reset accepts sync.
      step(1'b1, 1'b1, 1'b1, 4'h1);
      expect_all("bf1", 4'h1, 4'h0, 4'h0, 4'h0, 4'b0001, 2'd1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h2);
      expect_all("bf2", 4'h1, 4'h2, 4'h0, 4'h0, 4'b0010, 2'd2, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h3);
      expect_all("bf3", 4'h1, 4'h2, 4'h3, 4'h0, 4'b0100, 2'd3, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h4);
      expect_all("bf4", 4'h1, 4'h2, 4'h3, 4'h4, 4'b1000, 2'd0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 4'hE);
      expect_all("bfi", 4'h1, 4'h2, 4'h3, 4'h4, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);

      // Hunt discard.
      step(1'b0, 1'b0, 1'b0, 4'h0);
      step(1'b1, 1'b1, 1'b0, 4'hA);
      expect_all("hdA", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'hB);
      expect_all("hdB", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 4'hC);
      expect_all("hdC", 4'hC, 4'h0, 4'h0, 4'h0, 4'b0001, 2'd1, 1'b1, 1'b0, 1'b0);

      // Gaps within a frame.
      step(1'b0, 1'b0, 1'b0, 4'h0);
      step(1'b1, 1'b1, 1'b1, 4'h5);
      expect_all("gp5", 4'h5, 4'h0, 4'h0, 4'h0, 4'b0001, 2'd1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 4'hD);
      expect_all("gpi1", 4'h5, 4'h0, 4'h0, 4'h0, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 4'hD);
      expect_all("gpi2", 4'h5, 4'h0, 4'h0, 4'h0, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h6);
      expect_all("gp6", 4'h5, 4'h6, 4'h0, 4'h0, 4'b0010, 2'd2, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 4'hD);
      expect_all("gpi3", 4'h5, 4'h6, 4'h0, 4'h0, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h7);
      expect_all("gp7", 4'h5, 4'h6, 4'h7, 4'h0, 4'b0100, 2'd3, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h8);
      expect_all("gp8", 4'h5, 4'h6, 4'h7, 4'h8, 4'b1000, 2'd0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 4'hD);
      expect_all("gpi4", 4'h5, 4'h6, 4'h7, 4'h8, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);

      // Misaligned sync while locked.
      step(1'b1, 1'b1, 1'b1, 4'h1);
      expect_all("ms1", 4'h1, 4'h6, 4'h7, 4'h8, 4'b0001, 2'd1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h2);
      expect_all("ms2", 4'h1, 4'h2, 4'h7, 4'h8, 4'b0010, 2'd2, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 4'h9);
      expect_all("ms9", 4'h9, 4'h2, 4'h7, 4'h8, 4'b0001, 2'd1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'h0);
      expect_all("msi", 4'h9, 4'h2, 4'h7, 4'h8, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);

      // Back-to-back frames with wrap.
      step(1'b0, 1'b0, 1'b0, 4'h0);
      step(1'b1, 1'b1, 1'b1, 4'h0);
      expect_all("bb0", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, 2'd1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h1);
      expect_all("bb1", 4'h0, 4'h1, 4'h0, 4'h0, 4'b0010, 2'd2, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h2);
      expect_all("bb2", 4'h0, 4'h1, 4'h2, 4'h0, 4'b0100, 2'd3, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h3);
      expect_all("bb3", 4'h0, 4'h1, 4'h2, 4'h3, 4'b1000, 2'd0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 4'h4);
      expect_all("bb4", 4'h4, 4'h1, 4'h2, 4'h3, 4'b0001, 2'd1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h5);
      expect_all("bb5", 4'h4, 4'h5, 4'h2, 4'h3, 4'b0010, 2'd2, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h6);
      expect_all("bb6", 4'h4, 4'h5, 4'h6, 4'h3, 4'b0100, 2'd3, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h7);
      expect_all("bb7", 4'h4, 4'h5, 4'h6, 4'h7, 4'b1000, 2'd0, 1'b1, 1'b1, 1'b0);

      // Reset mid-frame.
      step(1'b0, 1'b0, 1'b0, 4'h0);
      step(1'b1, 1'b1, 1'b1, 4'h1);
      step(1'b1, 1'b1, 1'b0, 4'h2);
      expect_all("rm2", 4'h1, 4'h2, 4'h0, 4'h0, 4'b0010, 2'd2, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'h5);
      expect_all("rmr", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h3);
      expect_all("rm3", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
